fighter_stats: RTL and testbench

//   Parametrised successor to the per-character stat block. Latches a class roster entry on

---
 rtl/fighter_stats_if.sv | 41 ++++
 rtl/fighter_stats.sv | 191 +++++++++++++++++++
 tb/tb_fighter_stats.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fighter_stats_if.sv
// Bundle between the combat controller (master) and one fighter_stats instance (slave).
interface fighter_stats_if #(
  parameter int HP_W   = 9,
  parameter int SP_W   = 5,
  parameter int DMG_W  = 6,
  parameter int COST_W = 3
) ();
  logic              tick;
  logic              start;
  logic [1:0]        class_sel;
  logic              hit_valid;
  logic [DMG_W-1:0]  hit_dmg;
  logic              heal_valid;
  logic [DMG_W-1:0]  heal_amt;
  logic              spend_valid;
  logic [COST_W-1:0] spend_cost;
  logic              spend_ok;
  logic              spend_fail;
  logic [HP_W-1:0]   health;
  logic [SP_W-1:0]   special;
  logic [2:0]        speed;
  logic [2:0]        dodge;
  logic [2:0]        color;
  logic [1:0]        state;
  logic              ko_pulse;
  logic              dodge_pulse;

  modport master (
    output tick, start, class_sel, hit_valid, hit_dmg, heal_valid, heal_amt,
           spend_valid, spend_cost,
    input  spend_ok, spend_fail, health, special, speed, dodge, color, state,
           ko_pulse, dodge_pulse
  );

  modport slave (
    input  tick, start, class_sel, hit_valid, hit_dmg, heal_valid, heal_amt,
           spend_valid, spend_cost,
    output spend_ok, spend_fail, health, special, speed, dodge, color, state,
           ko_pulse, dodge_pulse
  );
endinterface

// File: rtl/fighter_stats.sv
// Per-player health/special tracker with invulnerability, regen and KO detection.
// Optional hit evasion via an 8-bit LFSR when FIGHTER_DODGE_EN is defined.
module fighter_stats #(
  parameter int HP_W         = 9,
  parameter int SP_W         = 5,
  parameter int DMG_W        = 6,
  parameter int COST_W       = 3,
  parameter int REGEN_TICKS  = 16,
  parameter int INVULN_TICKS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fighter_stats_if.slave  bus
);
  // state  | meaning
  // IDLE   | no class loaded, inputs ignored
  // ALIVE  | hits land, regen runs
  // INVULN | hits dropped until invuln counter expires
  // KO     | health 0, frozen until start
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ALIVE  = 2'd1;
  localparam logic [1:0] S_INVULN = 2'd2;
  localparam logic [1:0] S_KO     = 2'd3;

  localparam int RW = $clog2(REGEN_TICKS + 1);
  localparam int IW = $clog2(INVULN_TICKS + 1);
  localparam int XW = HP_W + 2;

  logic [1:0]      state_q,   state_d;
  logic [HP_W-1:0] health_q,  health_d;
  logic [SP_W-1:0] special_q, special_d;
  logic [HP_W-1:0] max_hp_q,  max_hp_d;
  logic [SP_W-1:0] max_sp_q,  max_sp_d;
  logic [2:0]      speed_q,   speed_d;
  logic [2:0]      dodge_q,   dodge_d;
  logic [2:0]      color_q,   color_d;
  logic [RW-1:0]   regen_q,   regen_d;
  logic [IW-1:0]   invuln_q,  invuln_d;
  logic            ok_q, ok_d, fail_q, fail_d, ko_q, ko_d, dp_q, dp_d;

  logic [HP_W-1:0] rost_hp;
  logic [SP_W-1:0] rost_sp;
  logic [2:0]      rost_spd, rost_dg, rost_col;
  logic            dodged;
  logic [XW-1:0]   dmg_x, heal_x;
  logic signed [XW-1:0] sum;
  logic [HP_W-1:0] hp_new;
  logic [SP_W-1:0] sp_v, cost_x;

  always_comb begin
    case (bus.class_sel)
      2'd0:    begin rost_hp = HP_W'(175); rost_spd = 3'd4; rost_dg = 3'd5; rost_sp = SP_W'(8);  rost_col = 3'b110; end
      2'd1:    begin rost_hp = HP_W'(150); rost_spd = 3'd6; rost_dg = 3'd7; rost_sp = SP_W'(10); rost_col = 3'b011; end
      2'd2:    begin rost_hp = HP_W'(200); rost_spd = 3'd2; rost_dg = 3'd5; rost_sp = SP_W'(10); rost_col = 3'b000; end
      default: begin rost_hp = HP_W'(150); rost_spd = 3'd7; rost_dg = 3'd7; rost_sp = SP_W'(8);  rost_col = 3'b010; end
    endcase
  end

`ifdef FIGHTER_DODGE_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign dodged = bus.hit_valid && (state_q == S_ALIVE) && (lfsr_q[3:0] < {1'b0, dodge_q});
`else
  assign dodged = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    health_d  = health_q;
    special_d = special_q;
    max_hp_d  = max_hp_q;
    max_sp_d  = max_sp_q;
    speed_d   = speed_q;
    dodge_d   = dodge_q;
    color_d   = color_q;
    regen_d   = regen_q;
    invuln_d  = invuln_q;
    ok_d      = 1'b0;
    fail_d    = 1'b0;
    ko_d      = 1'b0;
    dp_d      = 1'b0;
    dmg_x     = '0;
    heal_x    = '0;
    sum       = '0;
    hp_new    = health_q;
    sp_v      = special_q;
    cost_x    = SP_W'(bus.spend_cost);

    if (bus.start) begin
      health_d  = rost_hp;
      special_d = rost_sp;
      max_hp_d  = rost_hp;
      max_sp_d  = rost_sp;
      speed_d   = rost_spd;
      dodge_d   = rost_dg;
      color_d   = rost_col;
      regen_d   = '0;
      invuln_d  = '0;
      state_d   = S_ALIVE;
    end else if (state_q == S_ALIVE || state_q == S_INVULN) begin
      if (bus.hit_valid && state_q == S_ALIVE && !dodged) dmg_x = XW'(bus.hit_dmg);
      if (bus.heal_valid) heal_x = XW'(bus.heal_amt);
      // widened so heal overshoot and damage underflow both clamp cleanly
      sum = $signed({2'b00, health_q}) + $signed(heal_x) - $signed(dmg_x);
      if (sum < 0)                                hp_new = '0;
      else if (sum > $signed({2'b00, max_hp_q}))  hp_new = max_hp_q;
      else                                        hp_new = sum[HP_W-1:0];
      health_d = hp_new;
      dp_d     = dodged;

      if (bus.spend_valid) begin
        if (cost_x <= special_q) begin
          sp_v = special_q - cost_x;
          ok_d = 1'b1;
        end else begin
          fail_d = 1'b1;
        end
      end
      if (bus.tick) begin
        if (regen_q == RW'(REGEN_TICKS - 1)) begin
          regen_d = '0;
          if (sp_v < max_sp_q) sp_v = sp_v + 1'b1;
        end else begin
          regen_d = regen_q + 1'b1;
        end
      end
      special_d = sp_v;

      if (hp_new == '0) begin
        state_d = S_KO;
        ko_d    = 1'b1;
      end else if (dmg_x != '0) begin
        state_d  = S_INVULN;
        invuln_d = IW'(INVULN_TICKS);
      end else if (state_q == S_INVULN && bus.tick) begin
        invuln_d = invuln_q - 1'b1;
        if (invuln_q == IW'(1)) state_d = S_ALIVE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      health_q  <= '0;
      special_q <= '0;
      max_hp_q  <= '0;
      max_sp_q  <= '0;
      speed_q   <= '0;
      dodge_q   <= '0;
      color_q   <= '0;
      regen_q   <= '0;
      invuln_q  <= '0;
      ok_q      <= 1'b0;
      fail_q    <= 1'b0;
      ko_q      <= 1'b0;
      dp_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      health_q  <= health_d;
      special_q <= special_d;
      max_hp_q  <= max_hp_d;
      max_sp_q  <= max_sp_d;
      speed_q   <= speed_d;
      dodge_q   <= dodge_d;
      color_q   <= color_d;
      regen_q   <= regen_d;
      invuln_q  <= invuln_d;
      ok_q      <= ok_d;
      fail_q    <= fail_d;
      ko_q      <= ko_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.health      = health_q;
  assign bus.special     = special_q;
  assign bus.speed       = speed_q;
  assign bus.dodge       = dodge_q;
  assign bus.color       = color_q;
  assign bus.spend_ok    = ok_q;
  assign bus.spend_fail  = fail_q;
  assign bus.ko_pulse    = ko_q;
  assign bus.dodge_pulse = dp_q;
endmodule

// File: tb/tb_fighter_stats.sv
// Directed scenarios plus randomized traffic checked against an integer reference model.
module tb_fighter_stats;
  localparam int HP_W = 9, SP_W = 5, DMG_W = 6, COST_W = 3;
  localparam int REGEN_TICKS = 16, INVULN_TICKS = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fighter_stats_if #(.HP_W(HP_W), .SP_W(SP_W), .DMG_W(DMG_W), .COST_W(COST_W)) bus ();

  fighter_stats #(
    .HP_W(HP_W), .SP_W(SP_W), .DMG_W(DMG_W), .COST_W(COST_W),
    .REGEN_TICKS(REGEN_TICKS), .INVULN_TICKS(INVULN_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int R_HP [4] = '{175, 150, 200, 150};
  int R_SPD[4] = '{4, 6, 2, 7};
  int R_DG [4] = '{5, 7, 5, 7};
  int R_SP [4] = '{8, 10, 10, 8};
  int R_COL[4] = '{6, 3, 0, 2};

  int m_hp, m_sp, m_maxhp, m_maxsp, m_spd, m_dg, m_col, m_st, m_inv, m_reg;
  int m_ok, m_fail, m_ko, m_dp;
`ifdef FIGHTER_DODGE_EN
  logic [7:0] m_lfsr;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hp = 0; m_sp = 0; m_maxhp = 0; m_maxsp = 0; m_spd = 0; m_dg = 0; m_col = 0;
    m_st = 0; m_inv = 0; m_reg = 0; m_ok = 0; m_fail = 0; m_ko = 0; m_dp = 0;
`ifdef FIGHTER_DODGE_EN
    m_lfsr = 8'hA5;
`endif
  endtask

  task automatic model_step(input int tk, st, cs, hv, hd, lv, la, sv, sc);
    int dmg, n, sp;
    bit dodged;
    m_ok = 0; m_fail = 0; m_ko = 0; m_dp = 0;
    dodged = 1'b0;
`ifdef FIGHTER_DODGE_EN
    dodged = (hv != 0) && (m_st == 1) && (int'(m_lfsr[3:0]) < m_dg);
`endif
    if (st != 0) begin
      m_hp = R_HP[cs]; m_maxhp = R_HP[cs];
      m_sp = R_SP[cs]; m_maxsp = R_SP[cs];
      m_spd = R_SPD[cs]; m_dg = R_DG[cs]; m_col = R_COL[cs];
      m_st = 1; m_inv = 0; m_reg = 0;
    end else if (m_st == 1 || m_st == 2) begin
      dmg = (hv != 0 && m_st == 1 && !dodged) ? hd : 0;
      n = m_hp + ((lv != 0) ? la : 0) - dmg;
      if (n < 0) n = 0;
      if (n > m_maxhp) n = m_maxhp;
      sp = m_sp;
      if (sv != 0) begin
        if (sc <= sp) begin sp -= sc; m_ok = 1; end
        else m_fail = 1;
      end
      if (tk != 0) begin
        m_reg++;
        if (m_reg == REGEN_TICKS) begin
          m_reg = 0;
          if (sp + 1 <= m_maxsp) sp++;
        end
      end
      m_dp = dodged;
      if (n == 0) begin
        m_st = 3; m_ko = 1;
      end else if (dmg > 0) begin
        m_st = 2; m_inv = INVULN_TICKS;
      end else if (m_st == 2 && tk != 0) begin
        m_inv--;
        if (m_inv == 0) m_st = 1;
      end
      m_hp = n; m_sp = sp;
    end
`ifdef FIGHTER_DODGE_EN
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
`endif
  endtask

  task automatic check_all();
    chk("health",      bus.health,      m_hp);
    chk("special",     bus.special,     m_sp);
    chk("state",       bus.state,       m_st);
    chk("speed",       bus.speed,       m_spd);
    chk("dodge",       bus.dodge,       m_dg);
    chk("color",       bus.color,       m_col);
    chk("spend_ok",    bus.spend_ok,    m_ok);
    chk("spend_fail",  bus.spend_fail,  m_fail);
    chk("ko_pulse",    bus.ko_pulse,    m_ko);
    chk("dodge_pulse", bus.dodge_pulse, m_dp);
  endtask

  // Called at posedge+1: drive one cycle of inputs, advance the model, check after the edge.
  task automatic cyc(input int tk, st, cs, hv, hd, lv, la, sv, sc);
    bus.tick        = tk[0];
    bus.start       = st[0];
    bus.class_sel   = 2'(cs);
    bus.hit_valid   = hv[0];
    bus.hit_dmg     = DMG_W'(hd);
    bus.heal_valid  = lv[0];
    bus.heal_amt    = DMG_W'(la);
    bus.spend_valid = sv[0];
    bus.spend_cost  = COST_W'(sc);
    model_step(tk, st, cs, hv, hd, lv, la, sv, sc);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int tk, st, cs, hv, hd, lv, la, sv, sc;
    rst_n = 1'b0;
    bus.tick = 0; bus.start = 0; bus.class_sel = 0; bus.hit_valid = 0; bus.hit_dmg = 0;
    bus.heal_valid = 0; bus.heal_amt = 0; bus.spend_valid = 0; bus.spend_cost = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_state", bus.state, 0);
    rst_n = 1'b1;

    // T1: load class 0
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_health", bus.health, 175); chk("t1_special", bus.special, 8);
    chk("t1_speed", bus.speed, 4);     chk("t1_color", bus.color, 6);

    // T2: hit, dropped hit in INVULN, recovery after 4 ticks
    cyc(0, 1, 2, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 50, 0, 0, 0, 0);
    chk("t2_health", bus.health, 150); chk("t2_state", bus.state, 2);
    cyc(0, 0, 0, 1, 50, 0, 0, 0, 0);
    chk("t2_invuln_hit", bus.health, 150);
    ticks(3);
    chk("t2_still_inv", bus.state, 2);
    ticks(1);
    chk("t2_alive", bus.state, 1);

    // T3: grind class 1 down to 10, then KO; KO is sticky against heal
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 50, 0, 0, 0, 0); ticks(4);
    cyc(0, 0, 0, 1, 50, 0, 0, 0, 0); ticks(4);
    cyc(0, 0, 0, 1, 40, 0, 0, 0, 0); ticks(4);
    chk("t3_hp10", bus.health, 10);
    cyc(0, 0, 0, 1, 20, 0, 0, 0, 0);
    chk("t3_ko_hp", bus.health, 0); chk("t3_ko_pulse", bus.ko_pulse, 1);
    chk("t3_ko_state", bus.state, 3);
    cyc(0, 0, 0, 0, 0, 1, 30, 1, 0);
    chk("t3_pulse_gone", bus.ko_pulse, 0); chk("t3_heal_ko", bus.health, 0);
    chk("t3_spend_ko", bus.spend_ok, 0);

    // T4: spend, refused spend, regen
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 7);
    chk("t4_ok", bus.spend_ok, 1); chk("t4_sp1", bus.special, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 3);
    chk("t4_fail", bus.spend_fail, 1); chk("t4_sp_keep", bus.special, 1);
    ticks(15);
    chk("t4_no_regen_yet", bus.special, 1);
    ticks(1);
    chk("t4_regen", bus.special, 2);

    // T5: hit and heal together clamp to max
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 20, 1, 30, 0, 0);
    chk("t5_clamp", bus.health, 175); chk("t5_state", bus.state, 2);

    // T6: asynchronous reset during INVULN, then reload
    async_reset();
    chk("t6_state", bus.state, 0);
    cyc(0, 1, 3, 0, 0, 0, 0, 0, 0);
    chk("t6_hp", bus.health, 150); chk("t6_speed", bus.speed, 7);

    for (int i = 0; i < 4000; i++) begin
      st = ($urandom_range(0, (m_st == 0 || m_st == 3) ? 7 : 80) == 0) ? 1 : 0;
      cs = $urandom_range(0, 3);
      tk = $urandom_range(0, 1);
      hv = ($urandom_range(0, 5) == 0) ? 1 : 0;
      hd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 25);
      lv = ($urandom_range(0, 7) == 0) ? 1 : 0;
      la = $urandom_range(0, 63);
      sv = ($urandom_range(0, 4) == 0) ? 1 : 0;
      sc = $urandom_range(0, 7);
      if ($urandom_range(0, 599) == 0) async_reset();
      cyc(tk, st, cs, hv, hd, lv, la, sv, sc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
